// File: rtl/cell_pos_reader_pkg.sv
// Shared types and constants for the cell position reader and its skid FIFO.
package cell_pos_reader_pkg;

    localparam int POS_WIDTH      = 32;
    localparam int FIFO_DEPTH     = 2;
    localparam int MEM_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_CNT   = 3'd1,
        ST_WAIT_CNT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/cell_pos_reader_pos_skid_fifo.sv
// Small circular FIFO of {last, pid, pos} absorbing RAM return data while the consumer stalls.
module pos_skid_fifo
    import cell_pos_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 3 * POS_WIDTH,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_pos,
    input  logic [ADDR_WIDTH-1:0]              push_pid,
    input  logic                               push_last,
    input  logic                               pop,
    output logic                               full,
    output logic                               empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic [DATA_WIDTH-1:0]              head_pos,
    output logic [ADDR_WIDTH-1:0]              head_pid,
    output logic                               head_last
);

    localparam int IW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] pos_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] pos_d  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pid_q  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pid_d  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q, last_d;
    logic [IW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign head_pos  = pos_q[rd_q];
    assign head_pid  = pid_q[rd_q];
    assign head_last = last_q[rd_q];

    always_comb begin
        pos_d   = pos_q;
        pid_d   = pid_q;
        last_d  = last_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            pos_d[wr_q]  = push_pos;
            pid_d[wr_q]  = push_pid;
            last_d[wr_q] = push_last;
            wr_d         = (wr_q == IW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = (rd_q == IW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pos_q[i] <= '0;
                pid_q[i] <= '0;
            end
            last_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            pos_q   <= pos_d;
            pid_q   <= pid_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count of one cell RAM, then streams every position out on a
// valid/ready port, issuing RAM reads only when the skid FIFO can absorb the return.
module cell_pos_reader
    import cell_pos_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 3 * POS_WIDTH,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cnt_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pos,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last
);

    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam int                    CW      = $clog2(FIFO_DEPTH + 1);
    localparam int                    LAT     = MEM_RD_LATENCY;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d, rd_ptr_q, rd_ptr_d;
    logic                            busy_q, busy_d, done_q, done_d, cnt_err_q, cnt_err_d;
    logic [LAT-1:0]                  vld_pipe_q, vld_pipe_d;
    logic [LAT-1:0][ADDR_WIDTH-1:0]  pid_pipe_q, pid_pipe_d;

    logic                  rd_cnt, rd_part;
    logic [ADDR_WIDTH-1:0] rd_addr, cnt_raw, cnt_clamp;
    logic                  fifo_full, fifo_empty, push_last, handshake, room;
    logic [CW-1:0]         fifo_count;
    logic [3:0]            occ;
    logic [DATA_WIDTH-1:0] head_pos;
    logic [ADDR_WIDTH-1:0] head_pid;
    logic                  head_last;

    assign cnt_raw   = mem_q[ADDR_WIDTH-1:0];
    assign cnt_clamp = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;

    assign out_valid = ~fifo_empty;
    assign handshake = out_valid & out_ready;
    assign out_pos   = out_valid ? head_pos : '0;
    assign out_pid   = out_valid ? head_pid : '0;
    assign out_last  = out_valid & head_last;

    assign mem_rden    = rd_cnt | rd_part;
    assign mem_address = rd_addr;
    assign mem_wren    = 1'b0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign cnt_err = cnt_err_q;

    assign push_last = (pid_pipe_q[LAT-1] == cnt_q);

    // Occupancy the FIFO will reach once every in-flight read lands, crediting this
    // cycle's pop so a continuously ready consumer sees one word per cycle.
    always_comb begin
        occ = 4'(fifo_count) - 4'(handshake);
        for (int i = 0; i < LAT; i++) begin
            occ = occ + 4'(vld_pipe_q[i]);
        end
    end

    assign room = (occ < 4'(FIFO_DEPTH)) && !(fifo_full && !handshake);

    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        pid_pipe_d    = pid_pipe_q;
        vld_pipe_d[0] = rd_part;
        pid_pipe_d[0] = rd_addr;
        for (int i = 1; i < LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            pid_pipe_d[i] = pid_pipe_q[i-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_ptr_d  = rd_ptr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_err_d = cnt_err_q;
        rd_cnt    = 1'b0;
        rd_part   = 1'b0;
        rd_addr   = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RD_CNT;
                    busy_d    = 1'b1;
                    cnt_err_d = 1'b0;
                    cnt_d     = '0;
                    rd_ptr_d  = '0;
                end
            end
            ST_RD_CNT: begin
                rd_cnt  = 1'b1;
                state_d = ST_WAIT_CNT;
            end
            ST_WAIT_CNT: begin
                cnt_d = cnt_clamp;
                if (cnt_raw > MAX_CNT) cnt_err_d = 1'b1;
                if (cnt_clamp == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    // FIFO is empty here, so particle 1 is fetched straight away.
                    rd_part  = 1'b1;
                    rd_addr  = ADDR_WIDTH'(1);
                    rd_ptr_d = ADDR_WIDTH'(2);
                    state_d  = (cnt_clamp == ADDR_WIDTH'(1)) ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (room) begin
                    rd_part = 1'b1;
                    rd_addr = rd_ptr_q;
                    if (rd_ptr_q == cnt_q) state_d  = ST_DRAIN;
                    else                   rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (handshake && head_last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_err_q  <= 1'b0;
            vld_pipe_q <= '0;
            pid_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_err_q  <= cnt_err_d;
            vld_pipe_q <= vld_pipe_d;
            pid_pipe_q <= pid_pipe_d;
        end
    end

    pos_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_pipe_q[LAT-1]),
        .push_pos  (mem_q),
        .push_pid  (pid_pipe_q[LAT-1]),
        .push_last (push_last),
        .pop       (handshake),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_pos  (head_pos),
        .head_pid  (head_pid),
        .head_last (head_last)
    );

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader: a behavioural 1-cycle RAM feeds the DUT.
module tb_cell_pos_reader;

    localparam int DW = 96;
    localparam int PN = 220;
    localparam int AW = 8;

    logic          clk, rst_n, start;
    logic          busy, done, cnt_err, mem_rden, mem_wren;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_q;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_pos;
    logic [AW-1:0] out_pid;

    logic [DW-1:0] ram [PN];

    int errors = 0;
    int checks = 0;

    cell_pos_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .cnt_err     (cnt_err),
        .mem_address (mem_address),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pos     (out_pos),
        .out_pid     (out_pid),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial mem_q = '0;
    always @(posedge clk) begin
        if (mem_rden) mem_q <= (int'(mem_address) < PN) ? ram[mem_address] : '0;
    end

    function automatic logic [DW-1:0] pat(input int i);
        return {32'(32'hA000_0000 + i), 32'(32'hB000_0000 + i), 32'(32'hC000_0000 + i)};
    endfunction

    task automatic fill(input logic [DW-1:0] cnt_word);
        ram[0] = cnt_word;
        for (int i = 1; i < PN; i++) ram[i] = pat(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW+2*AW+7:0] zv;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        fill('0);
        #3;
        zv = {busy, done, cnt_err, out_valid, out_last, mem_rden, mem_wren, mem_address, out_pid, out_pos, 1'b0};
        checks++;
        if (zv !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", zv); end
        step(); step();
        rst_n = 1'b1;
        step();
        zv = {busy, done, cnt_err, out_valid, out_last, mem_rden, mem_wren, mem_address, out_pid, out_pos, 1'b0};
        checks++;
        if (zv !== '0) begin errors++; $display("FAIL reset_idle got=%h exp=0", zv); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] a, b, c3, ep;
        logic [DW+AW+AW+4:0] got, exp;
        a  = 96'h0000_0011_0000_0012_0000_0013;
        b  = 96'h0000_0021_0000_0022_0000_0023;
        c3 = 96'h0000_0031_0000_0032_0000_0033;
        ram[0] = 96'd3; ram[1] = a; ram[2] = b; ram[3] = c3;
        out_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 9; c++) begin
            ep = (c == 4) ? a : (c == 5) ? b : (c == 6) ? c3 : '0;
            exp = {(c >= 4 && c <= 6), ((c >= 4 && c <= 6) ? AW'(c - 3) : AW'(0)), ep,
                   (c == 6), (c == 7), (c <= 7), (c <= 4), ((c >= 2 && c <= 4) ? AW'(c - 1) : AW'(0))};
            got = {out_valid, out_pid, out_pos, out_last, done, busy, mem_rden, mem_address};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL basic_c%0d got=%h exp=%h", c, got, exp); end
            step();
        end
        checks++;
        if (mem_wren !== 1'b0) begin errors++; $display("FAIL basic_wren got=%b exp=0", mem_wren); end
    endtask

    task automatic test_zero();
        logic [4:0] got, exp;
        ram[0] = 96'd0;
        out_ready = 1'b1;
        pulse_start();
        for (int c = 1; c <= 5; c++) begin
            exp = {1'b0, (c == 3), (c <= 3), 1'b0, (c == 1)};
            got = {out_valid, done, busy, cnt_err, mem_rden};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL zero_c%0d got=%b exp=%b", c, got, exp); end
            step();
        end
    endtask

    task automatic test_backpressure();
        bit rdy_pat [16] = '{1,1,0,0,1,0,1,1,0,0,0,1,0,1,1,1};
        int hs, max_addr;
        logic seen_done, prev_stall;
        logic [DW+AW:0] prev, cur;
        fill(96'd5);
        out_ready = 1'b1;
        hs = 0; max_addr = 0; seen_done = 1'b0; prev_stall = 1'b0; prev = '0;
        pulse_start();
        for (int c = 1; c <= 80 && !seen_done; c++) begin
            out_ready = rdy_pat[c % 16];
            #1;
            cur = {out_valid, out_pid, out_pos, out_last};
            if (prev_stall) begin
                checks++;
                if (cur !== prev) begin errors++; $display("FAIL bp_stable_c%0d got=%h exp=%h", c, cur, prev); end
            end
            if (mem_rden && int'(mem_address) > max_addr) max_addr = int'(mem_address);
            if (out_valid && out_ready) begin
                hs++;
                checks++;
                if ({out_pid, out_pos, out_last} !== {AW'(hs), pat(hs), (hs == 5)}) begin
                    errors++;
                    $display("FAIL bp_word%0d got=%h/%h/%b exp=%h/%h/%b", hs, out_pid, out_pos, out_last,
                             AW'(hs), pat(hs), (hs == 5));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = cur;
            if (done) seen_done = 1'b1;
            step();
        end
        out_ready = 1'b1;
        checks++;
        if (hs !== 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", hs); end
        checks++;
        if (max_addr > 5) begin errors++; $display("FAIL bp_max_addr got=%0d exp<=5", max_addr); end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL bp_done got=0 exp=1"); end
    endtask

    task automatic test_overflow();
        int hs;
        logic seen_done;
        fill(96'd250);
        out_ready = 1'b1;
        hs = 0; seen_done = 1'b0;
        pulse_start();
        for (int c = 1; c <= 400 && !seen_done; c++) begin
            if (out_valid && out_ready) begin
                hs++;
                checks++;
                if ({out_pid, out_pos, out_last} !== {AW'(hs), pat(hs), (hs == 219)}) begin
                    errors++;
                    $display("FAIL ovf_word%0d got=%h/%b exp=%h/%b", hs, out_pid, out_last, AW'(hs), (hs == 219));
                end
            end
            if (done) seen_done = 1'b1;
            step();
        end
        checks++;
        if (hs !== 219) begin errors++; $display("FAIL ovf_count got=%0d exp=219", hs); end
        checks++;
        if (cnt_err !== 1'b1) begin errors++; $display("FAIL ovf_cnt_err got=%b exp=1", cnt_err); end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL ovf_done got=0 exp=1"); end
    endtask

    task automatic test_ignore_start();
        int hs, dn;
        fill(96'd4);
        out_ready = 1'b1;
        hs = 0; dn = 0;
        pulse_start();
        checks++;
        if (cnt_err !== 1'b0) begin errors++; $display("FAIL ign_cnt_err_clear got=%b exp=0", cnt_err); end
        for (int c = 1; c <= 24; c++) begin
            if (out_valid && out_ready) begin
                hs++;
                checks++;
                if (out_pid !== AW'(hs)) begin errors++; $display("FAIL ign_pid%0d got=%0d exp=%0d", hs, out_pid, hs); end
            end
            if (done) dn++;
            start = (c == 5) || (done === 1'b1);
            step();
        end
        start = 1'b0;
        checks++;
        if (hs !== 4) begin errors++; $display("FAIL ign_count got=%0d exp=4", hs); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL ign_done_pulses got=%0d exp=1", dn); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int hs;
        logic seen_done;
        logic [DW+2*AW+7:0] zv;
        fill(96'd10);
        out_ready = 1'b1;
        hs = 0;
        pulse_start();
        for (int c = 1; c <= 30 && hs < 4; c++) begin
            if (out_valid && out_ready) hs++;
            step();
        end
        checks++;
        if (hs !== 4) begin errors++; $display("FAIL rst_pre_count got=%0d exp=4", hs); end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            zv = {busy, done, cnt_err, out_valid, out_last, mem_rden, mem_wren, mem_address, out_pid, out_pos, 1'b0};
            checks++;
            if (zv !== '0) begin errors++; $display("FAIL rst_mid_%0d got=%h exp=0", k, zv); end
            step();
        end
        rst_n = 1'b1;
        step();
        zv = {busy, done, cnt_err, out_valid, out_last, mem_rden, mem_wren, mem_address, out_pid, out_pos, 1'b0};
        checks++;
        if (zv !== '0) begin errors++; $display("FAIL rst_after got=%h exp=0", zv); end
        hs = 0; seen_done = 1'b0;
        pulse_start();
        for (int c = 1; c <= 40 && !seen_done; c++) begin
            if (out_valid && out_ready) begin
                hs++;
                checks++;
                if ({out_pid, out_pos, out_last} !== {AW'(hs), pat(hs), (hs == 10)}) begin
                    errors++;
                    $display("FAIL rst_word%0d got=%h/%b exp=%h/%b", hs, out_pid, out_last, AW'(hs), (hs == 10));
                end
            end
            if (done) seen_done = 1'b1;
            step();
        end
        checks++;
        if (hs !== 10) begin errors++; $display("FAIL rst_count got=%0d exp=10", hs); end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL rst_done got=0 exp=1"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cell_pos_reader.md
Name: cell_pos_reader

Overview:
- Sequencer directly downstream of one per-cell position RAM (single-port, 1-cycle registered read). Address 0 holds the particle count; addresses 1..count hold {posz, posy, posx}.
- On a start pulse it reads the count, then streams every particle position out on a valid/ready interface with particle index and last flag.
- Feeds the force-evaluation pipeline / position cache. Absorbs memory read latency under backpressure without dropping or duplicating entries.

Parameters:
- DATA_WIDTH, 96, position word width {posz,posy,posx}, 32 bits each.
- PARTICLE_NUM, 220, RAM depth in words, including the count word.
- ADDR_WIDTH, 8, RAM address width; also the width of the count and pid fields.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to stream the cell; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final handshake.
- cnt_err  out  1  sticky; count word exceeded PARTICLE_NUM-1; cleared by the next accepted start.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_rden  out  1  RAM read enable.
- mem_wren  out  1  tied 0.
- mem_q  in  DATA_WIDTH  RAM read data, valid 1 cycle after the mem_rden edge.
- out_valid  out  1  out_pos/out_pid/out_last are valid.
- out_ready  in  1  consumer accepts the word this cycle.
- out_pos  out  DATA_WIDTH  particle position.
- out_pid  out  ADDR_WIDTH  particle index, 1-based (equals the RAM address).
- out_last  out  1  marks the final particle.

Behaviour:
- Reset (asynchronous, rst_n=0): FSM goes to IDLE. All outputs 0, counters 0, FIFO emptied, in-flight tracker cleared. This applies mid-stream as well; no partial output persists after reset releases.
- FSM states: IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE.
- IDLE: start=1 is sampled at edge k. The machine goes to RD_CNT, busy=1 and cnt_err is cleared.
- RD_CNT (cycle k+1): mem_rden=1, mem_address=0, then go to WAIT_CNT.
- WAIT_CNT (cycle k+2): latch cnt = mem_q[ADDR_WIDTH-1:0].
  - If cnt > PARTICLE_NUM-1: clamp cnt to PARTICLE_NUM-1 and set cnt_err.
  - If cnt==0: go to DONE.
  - Otherwise go to STREAM with rd_ptr=1.
- STREAM issue rule: issue a read (mem_rden=1, mem_address=rd_ptr, rd_ptr++) only when FIFO free slots minus in-flight reads > 0. After the read at rd_ptr==cnt is issued, go to DRAIN.
- RAM return path: data returning 1 cycle after issue is pushed into a 2-entry skid FIFO together with pid and last=(pid==cnt).
- Output port: the FIFO head drives out_valid/out_pos/out_pid/out_last.
  - Handshake = out_valid & out_ready; it pops the head.
  - While out_valid=1 and out_ready=0, the outputs hold stable.
- Throughput: with out_ready held high, first out_valid is at cycle k+4 and one particle is delivered per cycle after that.
- DRAIN: wait until the handshake of the word with out_last=1, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, next state IDLE. A start arriving in the DONE cycle is ignored.
- start while busy: ignored, with no effect on the counters.
- mem_rden=0 and mem_address=0 whenever no read is issued.
- Width rules: rd_ptr/cnt are ADDR_WIDTH unsigned; cnt==PARTICLE_NUM-1 is a legal full cell and must not wrap.

Decomposition:
- Shared package (define.v): state encoding localparams; POS_WIDTH=32; FIFO_DEPTH=2; MEM_RD_LATENCY=1.
- Sub-module pos_skid_fifo:
  - 2-entry FIFO of {last, pid, pos}.
  - Ports: push, pop, full, empty, count.
  - Same clock and reset.

Test Plan:
- RAM[0]=3, RAM[1..3]=A,B,C, out_ready=1, start at edge 0 -> out_valid at cycles 4,5,6; pid 1,2,3; pos A,B,C; out_last only at cycle 6; done at 7; busy low at 8.
- RAM[0]=0, start -> no out_valid; done pulses at cycle 3; cnt_err=0.
- RAM[0]=5, out_ready toggling 1,0,0,1,... random -> exactly 5 handshakes in order pid 1..5, outputs stable while stalled, mem_address never exceeds 5, no FIFO overflow.
- RAM[0]=250 with PARTICLE_NUM=220 -> cnt_err=1, 219 particles streamed, last pid=219, done pulses.
- RAM[0]=10, rst_n low after the 4th handshake for 2 cycles, then start again -> all outputs 0 during reset; new stream restarts at pid 1 and completes all 10.
- start re-pulsed during STREAM, and in the DONE cycle -> ignored; only one stream and one done pulse.
